// File: rtl/mem_write_arbiter.sv
// Two-port write arbiter: DMA (port 0) and CNN writeback (port 1) share one
// registered memory write port, round-robin between bursts with a beat cap.
module mem_write_arbiter #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              last0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    output logic              gnt0,
    output logic              ack0,
    input  logic              req1,
    input  logic              last1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt1,
    output logic              ack1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             last_served, last_served_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

    // Prefer the port that was not served last; fall back to the other one.
    function automatic state_t pick(input logic ls, input logic r0, input logic r1);
        state_t res;
        res = IDLE;
        if (ls) begin
            if (r0)      res = OWN0;
            else if (r1) res = OWN1;
        end else begin
            if (r1)      res = OWN1;
            else if (r0) res = OWN0;
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_served <= 1'b1;
            beat_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            last_served <= last_served_nxt;
            beat_cnt    <= beat_cnt_nxt;
        end
    end

    // A burst that ends on its last beat still sees its own req high, so the
    // same port can be re-granted when the other port is not requesting.
    always_comb begin
        state_nxt       = state;
        last_served_nxt = last_served;
        beat_cnt_nxt    = beat_cnt;
        case (state)
            IDLE: begin
                state_nxt    = pick(last_served, req0, req1);
                beat_cnt_nxt = '0;
            end
            OWN0: begin
                if (!req0 || last0 || (beat_cnt == CAP_LAST)) begin
                    last_served_nxt = 1'b0;
                    beat_cnt_nxt    = '0;
                    state_nxt       = pick(1'b0, req0, req1);
                end else begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                end
            end
            OWN1: begin
                if (!req1 || last1 || (beat_cnt == CAP_LAST)) begin
                    last_served_nxt = 1'b1;
                    beat_cnt_nxt    = '0;
                    state_nxt       = pick(1'b1, req0, req1);
                end else begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt    = IDLE;
                beat_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        gnt0 = (state == OWN0);
        gnt1 = (state == OWN1);
        ack0 = gnt0 & req0;
        ack1 = gnt1 & req1;
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            mem_we <= ack0 | ack1;
            if (ack0) begin
                mem_addr <= addr0;
                mem_data <= data0;
            end else if (ack1) begin
                mem_addr <= addr1;
                mem_data <= data1;
            end
        end
    end

endmodule
